// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 4;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags the one that reaches LIMIT.
// Instantiated by apb_master only when APB_TIMEOUT_EN is defined.
module apb_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the increment that would bring the count up to LIMIT.
  always_comb begin
    expired = inc && (cnt_q == CW'(LIMIT - 1));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, one-cycle response strobe.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog (apb_wdog) that aborts
// a transfer with rsp_err=1 after TIMEOUT_CYCLES wait states.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // Request port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // Response port
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB bus
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic timeout;
  logic done;

  // cmd_ready is registered so it reads 0 while reset is held.
  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign done   = (state_q == ACCESS) && (PREADY || timeout);

`ifdef APB_TIMEOUT_EN
  logic wd_expired;

  apb_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !PREADY),
    .expired (wd_expired)
  );

  assign timeout = wd_expired;
`else
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SETUP is always a single cycle, ACCESS holds until done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from the upcoming state, so the bus pins come straight from flops.
  always_comb begin
    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = done;
  end

  // Datapath next-state: latch the command on accept, capture the response on completion.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end
    if (done) begin
      // PREADY takes priority over a timeout in the same cycle.
      if (PREADY) begin
        rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        rsp_err_d   = PSLVERR;
      end else begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
